// File: rtl/pet_hunger_fsm_p.sv
// rtl/pet_hunger_fsm_p.sv - virtual-pet hunger/feeding FSM with tick decay, feed refill and step test mode
// Optional alarm output: define PET_ALARM_EN.
module pet_hunger_fsm_p #(
    parameter int LEVEL_W     = 3,
    parameter int LEVEL_MAX   = 7,
    parameter int HUNGRY_TH   = 4,
    parameter int STARVE_TH   = 1,
    parameter int DECAY_TICKS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               boton_comida,
    input  logic               senal_test,
    input  logic               boton_test,
    output logic [LEVEL_W-1:0] nivel_comida,
    output logic [1:0]         estado,
    output logic [2:0]         visualizacion,
    output logic               activo_comida,
    output logic               activo_medicina,
    output logic [1:0]         cambio_test,
`ifdef PET_ALARM_EN
    output logic               alarma,
`endif
    output logic [15:0]        salida_display
);

    localparam int CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] HUNGRY_L = LEVEL_W'(HUNGRY_TH);
    localparam logic [LEVEL_W-1:0] STARVE_L = LEVEL_W'(STARVE_TH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DECAY_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HAMBRE     = 2'd1,
        DESNUTRIDO = 2'd2,
        COMIENDO   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] nivel_q, nivel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cambio_q, cambio_d;
    logic               boton_test_prev;
    logic               senal_test_prev;
    logic               test_entry;
    logic               test_step;

    assign test_entry = senal_test & ~senal_test_prev;
    assign test_step  = boton_test & ~boton_test_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            nivel_q         <= MAX_L;
            cnt_q           <= '0;
            cambio_q        <= '0;
            boton_test_prev <= 1'b0;
            senal_test_prev <= 1'b0;
        end else begin
            state_q         <= state_d;
            nivel_q         <= nivel_d;
            cnt_q           <= cnt_d;
            cambio_q        <= cambio_d;
            boton_test_prev <= boton_test;
            senal_test_prev <= senal_test;
        end
    end

    always_comb begin
        state_d  = state_q;
        nivel_d  = nivel_q;
        cnt_d    = cnt_q;
        cambio_d = cambio_q;

        if (senal_test) begin
            // The entry cycle only clears the step counter; a coincident button edge is swallowed.
            if (test_entry) begin
                cambio_d = '0;
            end else if (test_step) begin
                state_d  = state_t'(state_q + 2'd1);
                cambio_d = cambio_q + 2'd1;
            end
        end else begin
            if (state_q != COMIENDO) begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (nivel_q != '0) nivel_d = nivel_q - LEVEL_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else if (tick && boton_comida && (nivel_q != MAX_L)) begin
                nivel_d = nivel_q + LEVEL_W'(1);
            end

            // Transitions look at the registered level, so they trail a level change by one cycle.
            case (state_q)
                IDLE: begin
                    if (nivel_q < HUNGRY_L) state_d = HAMBRE;
                end
                HAMBRE: begin
                    if (nivel_q < STARVE_L) state_d = DESNUTRIDO;
                    else if (boton_comida)  state_d = COMIENDO;
                end
                DESNUTRIDO: begin
                    if (boton_comida) state_d = COMIENDO;
                end
                COMIENDO: begin
                    if (boton_comida)            state_d = COMIENDO;
                    else if (nivel_q >= HUNGRY_L) state_d = IDLE;
                    else if (nivel_q >= STARVE_L) state_d = HAMBRE;
                    else                          state_d = DESNUTRIDO;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PET_ALARM_EN
    logic alarma_q;

    always_ff @(posedge clk) begin
        if (reset || senal_test || (state_q != DESNUTRIDO)) begin
            alarma_q <= 1'b0;
        end else if (tick) begin
            alarma_q <= ~alarma_q;
        end
    end

    assign alarma = alarma_q;
`endif

    assign nivel_comida    = nivel_q;
    assign estado          = state_q;
    assign visualizacion   = {1'b0, state_q};
    assign activo_comida   = (state_q != COMIENDO);
    assign activo_medicina = (state_q != COMIENDO);
    assign cambio_test     = cambio_q;
    assign salida_display  = {4'h0, 2'b00, cambio_q, 2'b00, state_q, 4'(nivel_q)};

endmodule
